// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the RV32I register-file writeback path:
// datapath width, load funct3 encodings and the writeback FSM states.
package writeback_unit_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data aligner: picks the byte/halfword lane out of a naturally aligned
// memory word, sign- or zero-extends it, and flags misaligned or illegal loads.
module writeback_unit_load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte and halfword lanes of the memory word
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane by load type and classify bad accesses
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB: begin
        data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      end
      F3_LBU: begin
        data = {{(XLEN-8){1'b0}}, byte_lane};
      end
      F3_LH: begin
        data       = {{(XLEN-16){half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LW: begin
        data       = XLEN'(rdata);
        misaligned = (addr_lo != 2'd0);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write initiator for the multicycle RV32I core. Takes either an
// ALU result or a load request, waits for load data when needed, and produces
// exactly one write pulse per retired result (never for x0).
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4:0]      load_rd,
  input  logic [2:0]      load_funct3,
  input  logic [1:0]      load_addr_lo,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            rf_write,
  output logic [4:0]      rf_reg_w,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_pending,
  output logic            load_fault
);

  // Counter must be able to hold TIMEOUT; a zero TIMEOUT leaves it unused
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  wb_state_e       state;
  logic [CW-1:0]   wait_count;
  logic [CW-1:0]   count_next;
  logic            timeout_hit;

  logic [4:0]      load_rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;

  logic [2:0]      align_funct3;
  logic [1:0]      align_addr_lo;
  logic [XLEN-1:0] align_data;
  logic            align_misaligned;
  logic            align_illegal;

  // ALU wins whenever both requests are present in IDLE
  assign alu_ready  = (state == IDLE);
  assign load_ready = (state == IDLE) && !alu_valid;

  assign count_next  = wait_count + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (count_next == CW'(TIMEOUT));

  // In IDLE the aligner checks the incoming request; afterwards it formats
  // the returning data using the latched load attributes
  assign align_funct3  = (state == IDLE) ? load_funct3  : funct3_q;
  assign align_addr_lo = (state == IDLE) ? load_addr_lo : addr_lo_q;

  writeback_unit_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3    (align_funct3),
    .addr_lo   (align_addr_lo),
    .rdata     (mem_rdata),
    .data      (align_data),
    .misaligned(align_misaligned),
    .illegal   (align_illegal)
  );

  // Writeback FSM with registered register-file and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_count   <= '0;
      rf_write     <= 1'b0;
      rf_reg_w     <= '0;
      rf_wdata     <= '0;
      load_fault   <= 1'b0;
      load_pending <= 1'b0;
      load_rd_q    <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
    end else begin
      rf_write   <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_valid) begin
            rf_reg_w <= alu_rd;
            rf_wdata <= alu_result;
            rf_write <= (alu_rd != 5'd0);
            state    <= WRITE;
          end else if (load_valid) begin
            load_rd_q <= load_rd;
            funct3_q  <= load_funct3;
            addr_lo_q <= load_addr_lo;
            if (align_misaligned || align_illegal) begin
              load_fault <= 1'b1;
            end else begin
              wait_count   <= '0;
              load_pending <= 1'b1;
              state        <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          wait_count <= count_next;
          if (mem_rvalid) begin
            rf_reg_w     <= load_rd_q;
            rf_wdata     <= align_data;
            rf_write     <= (load_rd_q != 5'd0);
            load_pending <= 1'b0;
            state        <= WRITE;
          end else if (timeout_hit) begin
            load_fault   <= 1'b1;
            load_pending <= 1'b0;
            state        <= IDLE;
          end
        end
        WRITE: begin
          load_pending <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side initiator for the integer register file in the multicycle RV32I core.
- Accepts ALU results, and load requests from the execute/memory sequencer.
- For loads: waits for the memory response, then aligns and sign/zero-extends the data.
- Drives the register file write port (register index, write enable, write data) with exactly one write pulse per retired result. Writes to x0 are suppressed.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT, 255, maximum number of LOAD_WAIT cycles before a load fault; 0 disables the timeout.

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered this cycle
- alu_ready  out  1  ALU result accepted (high when alu_valid and alu_ready are both high)
- alu_rd  in  5  destination register of the ALU result
- alu_result  in  XLEN  ALU result value
- load_valid  in  1  load request offered this cycle
- load_ready  out  1  load request accepted
- load_rd  in  5  destination register of the load
- load_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- load_addr_lo  in  2  effective address bits [1:0]
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  32  memory read word, naturally aligned
- rf_write  out  1  register file write enable
- rf_reg_w  out  5  register file write index
- rf_wdata  out  XLEN  register file write data
- load_pending  out  1  high while in LOAD_WAIT
- load_fault  out  1  one-cycle pulse: misaligned access, illegal funct3, or timeout

Behaviour:
- States: IDLE, LOAD_WAIT, WRITE.
- Reset (asynchronous): state IDLE, timeout counter 0.
  - Registered outputs clear to 0: rf_write, rf_reg_w, rf_wdata, load_fault, load_pending.
  - alu_ready is 1 during and after reset.
- Handshake outputs:
  - alu_ready = (state==IDLE).
  - load_ready = (state==IDLE) && !alu_valid.
  - The ALU path has priority when both requests arrive in the same cycle.
- IDLE, ALU accepted:
  - Latch rd and result into rf_reg_w and rf_wdata; next state WRITE.
- IDLE, load accepted:
  - Latch rd, funct3 and addr_lo.
  - Misaligned access is LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0. Illegal funct3 is 011, 110 or 111.
  - On misaligned or illegal: pulse load_fault in the next cycle, no write, stay in IDLE.
  - Otherwise: next state LOAD_WAIT, load_pending=1, counter cleared.
- LOAD_WAIT:
  - Counter increments every cycle.
  - On mem_rvalid: format the data, register it into rf_wdata, next state WRITE.
  - Byte lane = mem_rdata[8*addr_lo +: 8]; halfword lane = mem_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes the word through.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_rvalid: pulse load_fault, no write, go to IDLE.
  - If mem_rvalid arrives in the same cycle the counter reaches TIMEOUT, the data wins: no fault.
- WRITE:
  - rf_write = 1 for exactly one cycle, unless rf_reg_w==0, in which case rf_write stays 0.
  - Next state IDLE; load_pending=0.
- mem_rvalid in IDLE or WRITE is ignored.
- Reset asserted during LOAD_WAIT or WRITE: abort with no write. A late mem_rvalid after reset is ignored.
- Latency:
  - ALU: accept at cycle N, rf_write high at N+1, alu_ready high again at N+2.
  - Load: rf_write is high one cycle after the mem_rvalid cycle.
- Throughput: at most one write per 2 cycles; no buffering beyond one entry.

Decomposition:
- Shared core package holds:
  - funct3 load-encoding constants (LB/LH/LW/LBU/LHU);
  - the state enumeration;
  - the XLEN constant.
- One combinational sub-module is natural: load_align. It takes funct3, addr_lo and mem_rdata and returns the XLEN-wide extended data plus the misaligned and illegal flags. It is reusable by a future store-side aligner testbench.

Test Plan:
- ALU write: alu_valid with rd=5, result=0xDEADBEEF at cycle N → rf_write=1, rf_reg_w=5, rf_wdata=0xDEADBEEF at N+1 only; alu_ready=0 at N+1.
- x0 suppression: ALU rd=0, result=0x1234 → rf_write stays 0 throughout; FSM returns to IDLE after 2 cycles.
- Load formatting, each with mem_rdata=0x80FF7F01:
  - LB, addr_lo=3 → 0xFFFFFF80
  - LBU, addr_lo=3 → 0x00000080
  - LH, addr_lo=2 → 0xFFFF80FF
  - LHU, addr_lo=0 → 0x00007F01
  - LW → 0x80FF7F01
  - In every case rd is written one cycle after mem_rvalid.
- Faults:
  - LW addr_lo=1 → load_fault pulse, no LOAD_WAIT, no write.
  - funct3=011 → load_fault pulse.
  - TIMEOUT=4 with no mem_rvalid → load_fault after 4 LOAD_WAIT cycles, load_pending then 0.
  - A mem_rvalid arriving afterwards → no write.
- Priority: alu_valid and load_valid in the same cycle → ALU accepted, load_ready=0. Load accepted on the next IDLE cycle if still held.
- Reset mid-load: assert reset in LOAD_WAIT, release it, then pulse mem_rvalid → no rf_write, load_pending=0, all outputs at their reset values.
